// File: rtl/rolhas_pkg.sv
// Shared definitions for the cork-stock controller, the display multiplexer and the main FSM.
package rolhas_pkg;

   typedef enum logic [1:0] {
      OK     = 2'd0,
      PEDIDO = 2'd1,
      ESPERA = 2'd2,
      FALHA  = 2'd3
   } estado_t;

   localparam int W_ESTOQUE          = 7;
   localparam int CAPACIDADE_PAD     = 99;
   localparam int LIMIAR_BAIXO_PAD   = 10;
   localparam int LOTE_REFIL_PAD     = 50;
   localparam int TIMEOUT_CICLOS_PAD = 4096;

   typedef struct packed {
      logic [3:0] dezenas;
      logic [3:0] unidades;
   } bcd_t;

   // Repeated subtraction of ten; nine steps cover the whole 0..99 range.
   function automatic bcd_t para_bcd(input logic [W_ESTOQUE-1:0] valor);
      logic [W_ESTOQUE-1:0] resto;
      logic [3:0]           dez;
      bcd_t                 res;
      resto = valor;
      dez   = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (resto >= W_ESTOQUE'(10)) begin
            resto = resto - W_ESTOQUE'(10);
            dez   = dez + 4'd1;
         end
      end
      res.dezenas  = dez;
      res.unidades = resto[3:0];
      return res;
   endfunction

endpackage

// File: rtl/bin_para_bcd.sv
// Combinational 7-bit binary to two-digit BCD conversion for stock values 0..99.
module bin_para_bcd
   import rolhas_pkg::*;
(
   input  logic [W_ESTOQUE-1:0] binario,
   output logic [3:0]           dezenas,
   output logic [3:0]           unidades
);

   bcd_t bcd;

   always_comb begin
      bcd      = para_bcd(binario);
      dezenas  = bcd.dezenas;
      unidades = bcd.unidades;
   end

endmodule

// File: rtl/controle_rolhas.sv
// Cork magazine stock counter with saturating update, feeder refill handshake,
// refill timeout alarm and sticky shortage flag. All outputs registered.
module controle_rolhas
   import rolhas_pkg::*;
#(
   parameter int CAPACIDADE      = CAPACIDADE_PAD,
   parameter int LIMIAR_BAIXO    = LIMIAR_BAIXO_PAD,
   parameter int LOTE_REFIL      = LOTE_REFIL_PAD,
   parameter int TIMEOUT_CICLOS  = TIMEOUT_CICLOS_PAD,
   parameter int ESTOQUE_INICIAL = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 consumo,
   input  logic                 carga,
   input  logic                 refil_ack,
   input  logic                 limpa_alarme,
   output logic [W_ESTOQUE-1:0] estoque,
   output logic [3:0]           est_dezenas,
   output logic [3:0]           est_unidades,
   output logic                 refil_req,
   output logic                 parar,
   output logic                 alarme,
   output logic                 erro_falta
);

   localparam int W_CNT  = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam int W_SOMA = W_ESTOQUE + 2;

   localparam logic [W_CNT-1:0]     CNT_FIM        = W_CNT'(TIMEOUT_CICLOS - 1);
   localparam logic [W_ESTOQUE-1:0] LIMIAR_V       = W_ESTOQUE'(LIMIAR_BAIXO);
   localparam logic [W_ESTOQUE-1:0] CAPACIDADE_V   = W_ESTOQUE'(CAPACIDADE);
   localparam logic [W_ESTOQUE-1:0] INICIAL_V      = W_ESTOQUE'(ESTOQUE_INICIAL);
   localparam estado_t              ESTADO_INICIAL = (ESTOQUE_INICIAL > LIMIAR_BAIXO) ? OK : PEDIDO;
   localparam bcd_t                 BCD_INICIAL    = para_bcd(INICIAL_V);

   estado_t              estado_reg, estado_next;
   logic [W_CNT-1:0]     cnt_reg, cnt_next;
   logic [W_ESTOQUE-1:0] estoque_next;
   logic [W_SOMA-1:0]    soma;
   logic                 consumo_eff, ack_eff;
   logic [3:0]           dezenas_next, unidades_next;

   // Consumption never underflows because it is masked at zero stock.
   always_comb begin
      consumo_eff = consumo & (estoque != '0);
      ack_eff     = refil_ack & refil_req;
      soma        = W_SOMA'(estoque) + W_SOMA'(carga)
                  + (ack_eff ? W_SOMA'(LOTE_REFIL) : '0)
                  - W_SOMA'(consumo_eff);
      estoque_next = (soma > W_SOMA'(CAPACIDADE_V)) ? CAPACIDADE_V : soma[W_ESTOQUE-1:0];
   end

   bin_para_bcd u_bcd (
      .binario  (estoque_next),
      .dezenas  (dezenas_next),
      .unidades (unidades_next)
   );

   always_comb begin
      estado_next = estado_reg;
      case (estado_reg)
         OK:     if (estoque_next <= LIMIAR_V) estado_next = PEDIDO;
         PEDIDO: begin
            if (ack_eff)                estado_next = ESPERA;
            else if (cnt_reg == CNT_FIM) estado_next = FALHA;
         end
         ESPERA: estado_next = (estoque <= LIMIAR_V) ? PEDIDO : OK;
         FALHA:  if (limpa_alarme) estado_next = (estoque <= LIMIAR_V) ? PEDIDO : OK;
         default: estado_next = ESTADO_INICIAL;
      endcase
      // Counter only runs while the request stays up; any entry into PEDIDO starts from zero.
      cnt_next = ((estado_reg == PEDIDO) && (estado_next == PEDIDO)) ? cnt_reg + W_CNT'(1) : '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_reg   <= ESTADO_INICIAL;
         cnt_reg      <= '0;
         estoque      <= INICIAL_V;
         est_dezenas  <= BCD_INICIAL.dezenas;
         est_unidades <= BCD_INICIAL.unidades;
         refil_req    <= (ESTADO_INICIAL == PEDIDO);
         parar        <= (ESTOQUE_INICIAL == 0);
         alarme       <= 1'b0;
         erro_falta   <= 1'b0;
      end else begin
         estado_reg   <= estado_next;
         cnt_reg      <= cnt_next;
         estoque      <= estoque_next;
         est_dezenas  <= dezenas_next;
         est_unidades <= unidades_next;
         refil_req    <= (estado_next == PEDIDO);
         parar        <= (estoque_next == '0);
         alarme       <= (estado_next == FALHA);
         if (consumo && (estoque == '0)) erro_falta <= 1'b1;
      end
   end

endmodule

// File: tb/tb_controle_rolhas.sv
// Scoreboard bench for controle_rolhas: a behavioural model queues the expected outputs per edge.
module tb_controle_rolhas;

   localparam int CAP   = 99;
   localparam int LIM   = 10;
   localparam int LOTE  = 50;
   localparam int TMO   = 4096;
   localparam int S_OK  = 0;
   localparam int S_PED = 1;
   localparam int S_ESP = 2;
   localparam int S_FAL = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       consumo = 1'b0, carga = 1'b0, refil_ack = 1'b0, limpa_alarme = 1'b0;
   logic [6:0] estoque;
   logic [3:0] est_dezenas, est_unidades;
   logic       refil_req, parar, alarme, erro_falta;

   int n_checks = 0;
   int n_pass   = 0;

   int m_est, m_state, m_cnt, m_erro;
   logic [18:0] sb_q[$];

   controle_rolhas #(
      .CAPACIDADE      (CAP),
      .LIMIAR_BAIXO    (LIM),
      .LOTE_REFIL      (LOTE),
      .TIMEOUT_CICLOS  (TMO),
      .ESTOQUE_INICIAL (0)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .consumo      (consumo),
      .carga        (carga),
      .refil_ack    (refil_ack),
      .limpa_alarme (limpa_alarme),
      .estoque      (estoque),
      .est_dezenas  (est_dezenas),
      .est_unidades (est_unidades),
      .refil_req    (refil_req),
      .parar        (parar),
      .alarme       (alarme),
      .erro_falta   (erro_falta)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [18:0] observado();
      return {estoque, est_dezenas, est_unidades, refil_req, parar, alarme, erro_falta};
   endfunction

   task automatic modelo_reset();
      m_est = 0; m_state = S_PED; m_cnt = 0; m_erro = 0;
   endtask

   // Model one edge from the inputs currently applied; returns expected outputs.
   function automatic logic [18:0] modelo(input bit c, input bit l, input bit a, input bit la);
      int n, ns;
      bit ce, ae;
      ce = c && (m_est != 0);
      ae = a && (m_state == S_PED);
      n  = m_est - int'(ce) + int'(l) + (ae ? LOTE : 0);
      if (n > CAP) n = CAP;
      if (c && m_est == 0) m_erro = 1;
      ns = m_state;
      case (m_state)
         S_OK:  if (n <= LIM) ns = S_PED;
         S_PED: if (ae) ns = S_ESP; else if (m_cnt == TMO - 1) ns = S_FAL;
         S_ESP: ns = (m_est <= LIM) ? S_PED : S_OK;
         default: if (la) ns = (m_est <= LIM) ? S_PED : S_OK;
      endcase
      m_cnt   = (m_state == S_PED && ns == S_PED) ? m_cnt + 1 : 0;
      m_state = ns;
      m_est   = n;
      return {7'(n), 4'(n / 10), 4'(n % 10), ns == S_PED, n == 0, ns == S_FAL, m_erro[0]};
   endfunction

   task automatic step(input bit c, input bit l, input bit a, input bit la);
      logic [18:0] esperado;
      consumo = c; carga = l; refil_ack = a; limpa_alarme = la;
      sb_q.push_back(modelo(c, l, a, la));
      @(posedge clock);
      #1;
      esperado = sb_q.pop_front();
      check_val("saidas", 32'(observado()), 32'(esperado));
      consumo = 0; carga = 0; refil_ack = 0; limpa_alarme = 0;
   endtask

   initial begin
      modelo_reset();
      repeat (2) @(posedge clock);
      #1;
      check_val("reset_estoque", 32'(estoque), 0);
      check_val("reset_parar", 32'(parar), 1);
      check_val("reset_req", 32'(refil_req), 1);
      check_val("reset_alarme_erro", 32'({alarme, erro_falta}), 0);
      reset = 1'b1;

      // Empty magazine, no ack: request times out after TMO cycles in PEDIDO.
      repeat (TMO - 1) step(0, 0, 0, 0);
      check_val("pre_timeout_alarme", 32'(alarme), 0);
      step(0, 0, 0, 0);
      check_val("timeout_alarme", 32'(alarme), 1);
      check_val("timeout_req", 32'(refil_req), 0);
      step(0, 0, 0, 1);
      check_val("limpa_req", 32'(refil_req), 1);
      check_val("limpa_alarme", 32'(alarme), 0);

      // Shortage flag, then manual load.
      step(1, 0, 0, 0);
      check_val("falta_erro", 32'(erro_falta), 1);
      step(0, 1, 0, 0);
      check_val("carga_parar", 32'({estoque, parar}), {7'd1, 1'b0});

      // Ack together with the last cork: stock never hits zero.
      step(1, 0, 1, 0);
      check_val("ack_consumo_est", 32'({estoque, parar, refil_req}), {7'd50, 1'b0, 1'b0});
      step(0, 0, 0, 0);
      check_val("espera_ok_req", 32'(refil_req), 0);

      // Threshold crossing from 12.
      repeat (38) step(1, 0, 0, 0);
      check_val("est_12", 32'({estoque, refil_req}), {7'd12, 1'b0});
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      check_val("limiar_req", 32'({estoque, refil_req}), {7'd10, 1'b1});
      repeat (5) step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      check_val("refil_60", 32'({estoque, refil_req}), {7'd60, 1'b0});
      step(0, 0, 0, 0);
      check_val("ok_req_baixo", 32'(refil_req), 0);

      // Saturation at capacity.
      repeat (40) step(0, 1, 0, 0);
      check_val("sat_carga", 32'(estoque), 99);
      step(1, 1, 0, 0);
      check_val("consumo_carga_net0", 32'(estoque), 99);
      repeat (89) step(1, 0, 0, 0);
      check_val("req_em_10", 32'(refil_req), 1);
      repeat (50) step(0, 1, 0, 0);
      check_val("sem_retracao", 32'({estoque, refil_req}), {7'd60, 1'b1});
      step(0, 0, 1, 0);
      check_val("sat_ack", 32'({estoque, est_dezenas, est_unidades}), {7'd99, 4'd9, 4'd9});

      // Random traffic, ack also arriving outside PEDIDO.
      for (int i = 0; i < 400; i++)
         step($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
              $urandom_range(15) == 0);

      // Bring to PEDIDO mid-count, then assert reset between edges.
      for (int i = 0; i < 300 && m_state != S_PED; i++) begin
         if (m_state == S_FAL) step(0, 0, 0, 1);
         else step(1, 0, 0, 0);
      end
      check_val("pedido_antes_reset", 32'(refil_req), 1);
      repeat (3) step(0, 1, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      check_val("async_estoque_bcd", 32'({estoque, est_dezenas, est_unidades}), 0);
      check_val("async_flags", 32'({refil_req, parar, alarme, erro_falta}), 4'b1100);
      @(posedge clock);
      #1;
      reset = 1'b1;
      modelo_reset();
      repeat (5) step(0, 1, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
